inst_fetch_queue: RTL

Front-end fetch stage that sits directly upstream of the reorder buffer's issue logic. It fetches instruction words from instruction memory through a request/acknowledge handshake and buffers them with their PCs in a FIFO. It presents the oldest entry to the reorder buffer, which then drives CDB_inst. On a redirect from the reorder buffer (branch resolution), it flushes the queue and restarts fetch at the new PC.

---
 rtl/inst_fetch_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetches instruction words over a req/ack handshake and buffers {inst, pc}
// in a first-word-fall-through FIFO for the reorder buffer; a redirect flushes and restarts fetch.
module inst_fetch_queue #(
    parameter int WORD_SIZE = 32,
    parameter int QUEUE_DEPTH = 8,
    parameter int PTR_WIDTH = 3,
    parameter logic [WORD_SIZE-1:0] PC_RESET = '0,
    parameter logic [WORD_SIZE-1:0] PC_STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_data,
    output logic                 issue_valid,
    output logic [WORD_SIZE-1:0] issue_inst,
    output logic [WORD_SIZE-1:0] issue_pc,
    input  logic                 issue_ready,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [PTR_WIDTH:0]   queue_count
);
    typedef enum logic [1:0] {IDLE, REQ, SQUASH} state_t;
    localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH+1)'(QUEUE_DEPTH);
    state_t state_q, state_d;
    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d, squash_addr_q, squash_addr_d;
    logic [PTR_WIDTH-1:0] head_q, tail_q;
    logic [PTR_WIDTH:0] count_q, count_d;
    logic [WORD_SIZE-1:0] inst_q [QUEUE_DEPTH];
    logic [WORD_SIZE-1:0] pc_q [QUEUE_DEPTH];
    logic push, pop;

    // redirect outranks both an ack and an issue handshake in the same cycle
    assign push = (state_q == REQ) && imem_ack && !redirect;
    assign pop = issue_valid && issue_ready && !redirect;
    assign count_d = redirect ? '0 : count_q + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);

    assign imem_req = state_q != IDLE;
    assign imem_addr = (state_q == SQUASH) ? squash_addr_q : fetch_pc_q;
    assign issue_valid = count_q != '0;
    assign issue_inst = inst_q[head_q];
    assign issue_pc = pc_q[head_q];
    assign queue_count = count_q;

    always_comb begin
        state_d = state_q;
        fetch_pc_d = fetch_pc_q;
        squash_addr_d = squash_addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d = REQ;
                end else if (count_q < FULL) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack && !redirect) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d = (count_d < FULL) ? REQ : IDLE;
                end else if (imem_ack) begin
                    fetch_pc_d = redirect_pc;
                end else if (redirect) begin
                    squash_addr_d = fetch_pc_q;
                    fetch_pc_d = redirect_pc;
                    state_d = SQUASH;
                end
            end
            SQUASH: begin
                // the abandoned request stays up until memory acks it; its data is dropped
                fetch_pc_d = redirect ? redirect_pc : fetch_pc_q;
                state_d = imem_ack ? REQ : SQUASH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            fetch_pc_q <= PC_RESET;
            squash_addr_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            squash_addr_q <= squash_addr_d;
            count_q <= count_d;
            head_q <= redirect ? '0 : head_q + PTR_WIDTH'(pop);
            tail_q <= redirect ? '0 : tail_q + PTR_WIDTH'(push);
            if (push) begin
                inst_q[tail_q] <= imem_data;
                pc_q[tail_q] <= fetch_pc_q;
            end
        end
    end
endmodule
